// File: rtl/rgb_batch_pkg.sv
// Shared types and width helpers for the RGB batch packer and its banks.
package rgb_batch_pkg;

  localparam int DEF_CHANNELS    = 3;
  localparam int DEF_COLOR_WIDTH = 8;

  typedef logic [DEF_CHANNELS-1:0][DEF_COLOR_WIDTH-1:0] pixel_t;

  typedef enum logic {
    BANK_FREE = 1'b0,
    BANK_FULL = 1'b1
  } bank_state_t;

  // Slot pointer width; a 2-deep batch still needs one pointer bit.
  function automatic int ptr_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/rgb_batch_packer_bank.sv
// One batch bank: slot storage with pad-fill on close, plus count/last/state.
module batch_bank
  import rgb_batch_pkg::*;
#(
  parameter int CHANNELS    = 3,
  parameter int COLOR_WIDTH = 8,
  parameter int BATCH_SIZE  = 8,
  parameter logic [COLOR_WIDTH-1:0] PAD_VALUE = '0,
  localparam int PIX_W  = CHANNELS * COLOR_WIDTH,
  localparam int DATA_W = BATCH_SIZE * PIX_W,
  localparam int PTR_W  = ptr_width(BATCH_SIZE),
  localparam int CNT_W  = count_width(BATCH_SIZE)
) (
  input  logic              I_rgb_clk,
  input  logic              I_rst_n,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_ptr,
  input  logic [PIX_W-1:0]  wr_pixel,
  input  logic              wr_close,
  input  logic              wr_last,
  input  logic              rd_release,
  output logic [DATA_W-1:0] bank_data,
  output logic [CNT_W-1:0]  bank_count,
  output logic              bank_last,
  output bank_state_t       bank_state
);

  localparam logic [PIX_W-1:0] PAD_PIXEL = {CHANNELS{PAD_VALUE}};

  for (genvar gi = 0; gi < BATCH_SIZE; gi++) begin : g_slot
    logic [PIX_W-1:0] slot_reg;

    // Closing a short batch overwrites every slot above the closing one.
    always_ff @(posedge I_rgb_clk) begin
      if (wr_en) begin
        if (wr_ptr == PTR_W'(gi)) begin
          slot_reg <= wr_pixel;
        end else if (wr_close && (PTR_W'(gi) > wr_ptr)) begin
          slot_reg <= PAD_PIXEL;
        end
      end
    end

    assign bank_data[gi*PIX_W +: PIX_W] = slot_reg;
  end

  always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      bank_state <= BANK_FREE;
      bank_count <= '0;
      bank_last  <= 1'b0;
    end else if (wr_en && wr_close) begin
      bank_state <= BANK_FULL;
      bank_count <= CNT_W'(wr_ptr) + CNT_W'(1);
      bank_last  <= wr_last;
    end else if (rd_release) begin
      bank_state <= BANK_FREE;
    end
  end

endmodule

// File: rtl/rgb_batch_packer.sv
// Packs RGB pixels into fixed-size batches held in a ping-pong pair of banks,
// presented downstream through valid/ready with a sticky overflow flag.
module rgb_batch_packer
  import rgb_batch_pkg::*;
#(
  parameter int CHANNELS    = 3,
  parameter int COLOR_WIDTH = 8,
  parameter int BATCH_SIZE  = 8,
  parameter logic [COLOR_WIDTH-1:0] PAD_VALUE = '0,
  localparam int PIX_W  = CHANNELS * COLOR_WIDTH,
  localparam int DATA_W = BATCH_SIZE * PIX_W,
  localparam int PTR_W  = ptr_width(BATCH_SIZE),
  localparam int CNT_W  = count_width(BATCH_SIZE)
) (
  input  logic              I_rgb_clk,
  input  logic              I_rst_n,
  input  logic [PIX_W-1:0]  I_pixel,
  input  logic              I_pixel_valid,
  input  logic              I_line_end,
  output logic              O_batch_valid,
  input  logic              I_batch_ready,
  output logic [DATA_W-1:0] O_batch_data,
  output logic [CNT_W-1:0]  O_batch_count,
  output logic              O_batch_last,
  output logic              O_overflow,
  input  logic              I_clear_overflow
);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BATCH_SIZE - 1);

  logic             wr_bank_reg, wr_bank_next;
  logic             rd_bank_reg, rd_bank_next;
  logic [PTR_W-1:0] wr_ptr_reg,  wr_ptr_next;
  logic             overflow_reg, overflow_next;

  bank_state_t       bank_state [2];
  logic [DATA_W-1:0] bank_data  [2];
  logic [CNT_W-1:0]  bank_count [2];
  logic              bank_last  [2];

  logic wr_full, rd_full;
  logic write_en, close_batch, drop_pixel, handshake;

  // Write side looks only at registered bank state, so a same-cycle release
  // never rescues a pixel aimed at a full bank.
  assign wr_full     = (bank_state[wr_bank_reg] == BANK_FULL);
  assign rd_full     = (bank_state[rd_bank_reg] == BANK_FULL);
  assign write_en    = I_pixel_valid && !wr_full;
  assign drop_pixel  = I_pixel_valid && wr_full;
  assign close_batch = write_en && ((wr_ptr_reg == PTR_LAST) || I_line_end);
  assign handshake   = rd_full && I_batch_ready;

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    wr_bank_next  = wr_bank_reg;
    rd_bank_next  = rd_bank_reg;
    overflow_next = overflow_reg;

    if (close_batch) begin
      wr_ptr_next  = '0;
      wr_bank_next = ~wr_bank_reg;
    end else if (write_en) begin
      wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    end

    if (handshake) begin
      rd_bank_next = ~rd_bank_reg;
    end

    if (I_clear_overflow) begin
      overflow_next = 1'b0;
    end else if (drop_pixel) begin
      overflow_next = 1'b1;
    end
  end

  always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      wr_ptr_reg   <= '0;
      wr_bank_reg  <= 1'b0;
      rd_bank_reg  <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      wr_bank_reg  <= wr_bank_next;
      rd_bank_reg  <= rd_bank_next;
      overflow_reg <= overflow_next;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    batch_bank #(
      .CHANNELS    (CHANNELS),
      .COLOR_WIDTH (COLOR_WIDTH),
      .BATCH_SIZE  (BATCH_SIZE),
      .PAD_VALUE   (PAD_VALUE)
    ) u_bank (
      .I_rgb_clk  (I_rgb_clk),
      .I_rst_n    (I_rst_n),
      .wr_en      (write_en && (wr_bank_reg == 1'(gi))),
      .wr_ptr     (wr_ptr_reg),
      .wr_pixel   (I_pixel),
      .wr_close   (close_batch),
      .wr_last    (I_line_end),
      .rd_release (handshake && (rd_bank_reg == 1'(gi))),
      .bank_data  (bank_data[gi]),
      .bank_count (bank_count[gi]),
      .bank_last  (bank_last[gi]),
      .bank_state (bank_state[gi])
    );
  end

  assign O_batch_valid = rd_full;
  assign O_batch_data  = bank_data[rd_bank_reg];
  assign O_batch_count = bank_count[rd_bank_reg];
  assign O_batch_last  = bank_last[rd_bank_reg];
  assign O_overflow    = overflow_reg;

endmodule

// File: tb/tb_rgb_batch_packer.sv
// Self-checking bench: directed scenarios plus random traffic against a queue model.
module tb_rgb_batch_packer;
  import rgb_batch_pkg::*;

  localparam int CH  = 3;
  localparam int CWD = 8;
  localparam int BS  = 8;
  localparam int PW  = CH * CWD;
  localparam int DW  = BS * PW;
  localparam int CW  = $clog2(BS + 1);
  localparam logic [CWD-1:0] PAD = 8'h00;

  logic          I_rgb_clk;
  logic          I_rst_n;
  logic [PW-1:0] I_pixel;
  logic          I_pixel_valid;
  logic          I_line_end;
  logic          O_batch_valid;
  logic          I_batch_ready;
  logic [DW-1:0] O_batch_data;
  logic [CW-1:0] O_batch_count;
  logic          O_batch_last;
  logic          O_overflow;
  logic          I_clear_overflow;

  int checks = 0;
  int errors = 0;

  rgb_batch_packer #(
    .CHANNELS(CH), .COLOR_WIDTH(CWD), .BATCH_SIZE(BS), .PAD_VALUE(PAD)
  ) dut (
    .I_rgb_clk        (I_rgb_clk),
    .I_rst_n          (I_rst_n),
    .I_pixel          (I_pixel),
    .I_pixel_valid    (I_pixel_valid),
    .I_line_end       (I_line_end),
    .O_batch_valid    (O_batch_valid),
    .I_batch_ready    (I_batch_ready),
    .O_batch_data     (O_batch_data),
    .O_batch_count    (O_batch_count),
    .O_batch_last     (O_batch_last),
    .O_overflow       (O_overflow),
    .I_clear_overflow (I_clear_overflow)
  );

  initial I_rgb_clk = 1'b0;
  always #5 I_rgb_clk = ~I_rgb_clk;

  // Reference model: a FIFO of closed batches (at most two pending) and the open batch.
  typedef struct {
    logic [DW-1:0] data;
    int            count;
    logic          last;
  } batch_t;

  batch_t        bq[$];
  logic [PW-1:0] part[$];
  logic          ovf_m;

  function automatic logic [PW-1:0] rgb(input int r, input int g, input int b);
    pixel_t p;
    p[0] = 8'(r);
    p[1] = 8'(g);
    p[2] = 8'(b);
    return p;
  endfunction

  task automatic model_reset();
    bq.delete();
    part.delete();
    ovf_m = 1'b0;
  endtask

  // Apply one cycle of inputs, advance the model, return #1 after the edge.
  task automatic drive(input logic v, input logic [PW-1:0] px, input logic le,
                       input logic rdy, input logic clr);
    logic   hs, drop;
    batch_t b;
    I_pixel_valid    = v;
    I_pixel          = px;
    I_line_end       = le;
    I_batch_ready    = rdy;
    I_clear_overflow = clr;
    @(posedge I_rgb_clk);
    hs   = (bq.size() > 0) && rdy;
    drop = 1'b0;
    if (v) begin
      if (bq.size() == 2) begin
        drop = 1'b1;
      end else begin
        part.push_back(px);
        if (part.size() == BS || le) begin
          b.data = '0;
          for (int i = 0; i < BS; i++)
            b.data[i*PW +: PW] = (i < part.size()) ? part[i] : {CH{PAD}};
          b.count = part.size();
          b.last  = le;
          bq.push_back(b);
          part.delete();
        end
      end
    end
    if (hs) bq.delete(0);
    if (clr) ovf_m = 1'b0;
    else if (drop) ovf_m = 1'b1;
    #1;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, '0, 1'b0, rdy, 1'b0);
  endtask

  task automatic test_reset();
    I_rst_n = 1'b0;
    repeat (2) @(posedge I_rgb_clk);
    #1;
    model_reset();
    checks++;
    if (O_batch_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", O_batch_valid);
    end
    checks++;
    if (O_overflow !== 1'b0) begin
      errors++; $display("FAIL reset_overflow: got %b expected 0", O_overflow);
    end
    I_rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_full_batches();
    logic [DW-1:0] exp0;
    for (int i = 0; i < BS; i++) exp0[i*PW +: PW] = rgb(i, i + 1, i + 2);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, rgb(i, i + 1, i + 2), 1'b0, 1'b1, 1'b0);
      if (i == 6) begin
        checks++;
        if (O_batch_valid !== 1'b0) begin
          errors++; $display("FAIL full_early_valid: got %b expected 0", O_batch_valid);
        end
      end
      if (i == 7) begin
        checks++;
        if (O_batch_valid !== 1'b1) begin
          errors++; $display("FAIL full_valid: got %b expected 1", O_batch_valid);
        end
        checks++;
        if (O_batch_data[PW-1:0] !== 24'h020100) begin
          errors++; $display("FAIL full_pixel0: got %h expected 020100", O_batch_data[PW-1:0]);
        end
        checks++;
        if (O_batch_data !== exp0) begin
          errors++; $display("FAIL full_data: got %h expected %h", O_batch_data, exp0);
        end
        checks++;
        if (O_batch_count !== CW'(8) || O_batch_last !== 1'b0) begin
          errors++; $display("FAIL full_count_last: got %0d/%b expected 8/0", O_batch_count, O_batch_last);
        end
      end
    end
    checks++;
    if (O_batch_valid !== 1'b1 || O_batch_data[PW-1:0] !== 24'h0A0908) begin
      errors++; $display("FAIL full_second: got %b/%h expected 1/0a0908", O_batch_valid, O_batch_data[PW-1:0]);
    end
    idle(1'b1);
    checks++;
    if (O_batch_valid !== 1'b0) begin
      errors++; $display("FAIL full_drained: got %b expected 0", O_batch_valid);
    end
    $display("test_full_batches done");
  endtask

  task automatic test_line_end();
    logic [PW-1:0] p [3];
    for (int i = 0; i < 3; i++) begin
      p[i] = 24'($urandom);
      drive(1'b1, p[i], (i == 2), 1'b0, 1'b0);
    end
    checks++;
    if (O_batch_valid !== 1'b1 || O_batch_count !== CW'(3) || O_batch_last !== 1'b1) begin
      errors++; $display("FAIL line_end_meta: got %b/%0d/%b expected 1/3/1", O_batch_valid, O_batch_count, O_batch_last);
    end
    checks++;
    if (O_batch_data[3*PW-1:0] !== {p[2], p[1], p[0]}) begin
      errors++; $display("FAIL line_end_data: got %h expected %h", O_batch_data[3*PW-1:0], {p[2], p[1], p[0]});
    end
    checks++;
    if (O_batch_data[DW-1:3*PW] !== '0) begin
      errors++; $display("FAIL line_end_pad: got %h expected 0", O_batch_data[DW-1:3*PW]);
    end
    idle(1'b1);
    $display("test_line_end done");
  endtask

  task automatic test_backpressure();
    logic [PW-1:0] p [24];
    logic [DW-1:0] e0, e1;
    for (int i = 0; i < 24; i++) begin
      p[i] = 24'($urandom);
      drive(1'b1, p[i], 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < BS; i++) begin
      e0[i*PW +: PW] = p[i];
      e1[i*PW +: PW] = p[BS + i];
    end
    checks++;
    if (O_overflow !== 1'b1) begin
      errors++; $display("FAIL bp_overflow: got %b expected 1", O_overflow);
    end
    checks++;
    if (O_batch_valid !== 1'b1 || O_batch_data !== e0) begin
      errors++; $display("FAIL bp_batch0: got %b/%h expected 1/%h", O_batch_valid, O_batch_data, e0);
    end
    idle(1'b1);
    checks++;
    if (O_batch_valid !== 1'b1 || O_batch_data !== e1 || O_batch_count !== CW'(8)) begin
      errors++; $display("FAIL bp_batch1: got %b/%h/%0d expected 1/%h/8", O_batch_valid, O_batch_data, O_batch_count, e1);
    end
    idle(1'b1);
    checks++;
    if (O_batch_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drained: got %b expected 0", O_batch_valid);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (O_overflow !== 1'b0) begin
      errors++; $display("FAIL bp_clear: got %b expected 0", O_overflow);
    end
    $display("test_backpressure done");
  endtask

  task automatic test_simultaneous();
    logic [PW-1:0] p [16];
    logic [PW-1:0] y;
    for (int i = 0; i < 16; i++) begin
      p[i] = 24'($urandom);
      drive(1'b1, p[i], 1'b0, 1'b0, 1'b0);
    end
    drive(1'b1, 24'hABCDEF, 1'b0, 1'b1, 1'b0);
    checks++;
    if (O_overflow !== 1'b1) begin
      errors++; $display("FAIL simul_drop_overflow: got %b expected 1", O_overflow);
    end
    checks++;
    if (O_batch_valid !== 1'b1 || O_batch_data[PW-1:0] !== p[8]) begin
      errors++; $display("FAIL simul_next_batch: got %b/%h expected 1/%h", O_batch_valid, O_batch_data[PW-1:0], p[8]);
    end
    y = 24'h5A5A5A ^ 24'($urandom);
    drive(1'b1, y, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    checks++;
    if (O_batch_valid !== 1'b1 || O_batch_data[PW-1:0] !== y || O_batch_count !== CW'(1) || O_batch_last !== 1'b1) begin
      errors++; $display("FAIL simul_slot0: got %b/%h/%0d/%b expected 1/%h/1/1", O_batch_valid, O_batch_data[PW-1:0], O_batch_count, O_batch_last, y);
    end
    idle(1'b1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    $display("test_simultaneous done");
  endtask

  task automatic test_clear_priority();
    for (int i = 0; i < 16; i++) drive(1'b1, 24'($urandom), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 24'h111111, 1'b0, 1'b0, 1'b0);
    checks++;
    if (O_overflow !== 1'b1) begin
      errors++; $display("FAIL clr_set: got %b expected 1", O_overflow);
    end
    drive(1'b1, 24'h222222, 1'b0, 1'b0, 1'b1);
    checks++;
    if (O_overflow !== 1'b0) begin
      errors++; $display("FAIL clr_priority: got %b expected 0", O_overflow);
    end
    idle(1'b1);
    idle(1'b1);
    $display("test_clear_priority done");
  endtask

  task automatic test_reset_mid();
    logic [PW-1:0] p0;
    for (int i = 0; i < 13; i++) drive(1'b1, 24'($urandom), 1'b0, 1'b0, 1'b0);
    I_rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (O_batch_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_valid: got %b expected 0", O_batch_valid);
    end
    @(posedge I_rgb_clk);
    #1;
    I_rst_n = 1'b1;
    p0 = 24'($urandom);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, (i == 0) ? p0 : 24'($urandom), 1'b0, 1'b0, 1'b0);
      if (i == 6) begin
        checks++;
        if (O_batch_valid !== 1'b0) begin
          errors++; $display("FAIL rstmid_stale: got %b expected 0", O_batch_valid);
        end
      end
    end
    checks++;
    if (O_batch_valid !== 1'b1 || O_batch_count !== CW'(8) || O_batch_data[PW-1:0] !== p0) begin
      errors++; $display("FAIL rstmid_batch: got %b/%0d/%h expected 1/8/%h", O_batch_valid, O_batch_count, O_batch_data[PW-1:0], p0);
    end
    idle(1'b1);
    checks++;
    if (O_batch_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_single: got %b expected 0", O_batch_valid);
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      drive(($urandom_range(0, 9) < 7), 24'($urandom), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 1) == 1), ($urandom_range(0, 19) == 0));
      checks++;
      if (O_batch_valid !== (bq.size() > 0)) begin
        errors++; $display("FAIL rand_valid cycle %0d: got %b expected %b", n, O_batch_valid, (bq.size() > 0));
      end
      checks++;
      if (O_overflow !== ovf_m) begin
        errors++; $display("FAIL rand_overflow cycle %0d: got %b expected %b", n, O_overflow, ovf_m);
      end
      if (bq.size() > 0) begin
        checks++;
        if (O_batch_data !== bq[0].data || O_batch_count !== CW'(bq[0].count) || O_batch_last !== bq[0].last) begin
          errors++;
          $display("FAIL rand_batch cycle %0d: got %h/%0d/%b expected %h/%0d/%b", n,
                   O_batch_data, O_batch_count, O_batch_last, bq[0].data, bq[0].count, bq[0].last);
        end
      end
    end
    $display("test_random done");
  endtask

  initial begin
    I_rst_n          = 1'b1;
    I_pixel          = '0;
    I_pixel_valid    = 1'b0;
    I_line_end       = 1'b0;
    I_batch_ready    = 1'b0;
    I_clear_overflow = 1'b0;
    #2;
    test_reset();
    test_full_batches();
    test_line_end();
    test_backpressure();
    test_simultaneous();
    test_clear_priority();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
